// File: rtl/halt_controller_pkg.sv
// Shared definitions for the halt controller: state encoding,
// state width and the default HALT opcode (also used by the decoder).
package halt_controller_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [5:0] HALT_OPCODE_DEF = 6'h3F;

endpackage

// File: rtl/halt_controller_if.sv
// Processor-side bundle of the halt controller.
// master: drives opcode/instr_valid/resume; slave: drives the gating outputs.
interface halt_controller_if #(
    parameter int OPCODE_W = 6
);
    logic [OPCODE_W-1:0] opcode;
    logic                instr_valid;
    logic                resume;
    logic                pc_en;
    logic                wr_en_gate;
    logic                halted;
    logic [1:0]          state;

    modport master (
        output opcode, instr_valid, resume,
        input  pc_en, wr_en_gate, halted, state
    );

    modport slave (
        input  opcode, instr_valid, resume,
        output pc_en, wr_en_gate, halted, state
    );
endinterface

// File: rtl/halt_controller_sat_counter.sv
// Saturating up-counter used for cycle_count (HALT_CYCLE_COUNT_EN only).
// Ports: i_clk, i_rst (sync, high), i_en (count), o_count (value).
`ifdef HALT_CYCLE_COUNT_EN
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule
`endif

// File: rtl/halt_controller.sv
// Halt controller: INIT -> RUN -> HALTED FSM gating PC update and writes.
// Ports: clk, rst (sync, high), bus (halt_controller_if.slave:
// opcode, instr_valid, resume in; pc_en, wr_en_gate, halted, state out),
// cycle_count out when macro HALT_CYCLE_COUNT_EN is defined.
module halt_controller
    import halt_controller_pkg::*;
#(
    parameter int                  INIT_CYCLES = 1,
    parameter int                  OPCODE_W    = 6,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
    parameter int                  CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    halt_controller_if.slave bus
`ifdef HALT_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] cycle_count
`endif
);
    localparam int ICW = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);

    state_t         r_state;
    logic [ICW-1:0] r_init_cnt;
    logic           w_hit;
    logic           w_pc_en;
    logic           w_wr_en;
    logic           w_halted;
    logic [1:0]     w_state;

    assign w_hit = bus.instr_valid && (bus.opcode == HALT_OPCODE);

    // INIT_CYCLES=0 and 1 both spend one cycle in INIT; N>1 spends N.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= ICW'(INIT_CYCLES);
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt != '0) begin
                        r_init_cnt <= r_init_cnt - 1'b1;
                    end
                    if (r_init_cnt <= ICW'(1)) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_hit) begin
                        r_state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (bus.resume) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state    <= ST_INIT;
                    r_init_cnt <= ICW'(INIT_CYCLES);
                end
            endcase
        end
    end

    // Moore decode, plus same-cycle gating on halt hit and on resume.
    // rst forces the idle decode so nothing is enabled in a reset cycle.
    always_comb begin
        w_pc_en  = 1'b0;
        w_wr_en  = 1'b0;
        w_halted = 1'b0;
        w_state  = ST_INIT;
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    w_pc_en = !w_hit;
                    w_wr_en = !w_hit;
                    w_state = ST_RUN;
                end
                ST_HALTED: begin
                    w_pc_en  = bus.resume;
                    w_halted = 1'b1;
                    w_state  = ST_HALTED;
                end
                default: begin
                    w_state = ST_INIT;
                end
            endcase
        end
    end

    assign bus.pc_en      = w_pc_en;
    assign bus.wr_en_gate = w_wr_en;
    assign bus.halted     = w_halted;
    assign bus.state      = w_state;

`ifdef HALT_CYCLE_COUNT_EN
    logic w_cnt_en;

    assign w_cnt_en = (r_state == ST_RUN);

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (w_cnt_en),
        .o_count (cycle_count)
    );
`endif
endmodule

// File: tb/tb_halt_controller.sv
// Randomized scoreboard bench for halt_controller against a
// cycle-level behavioural model of its modes and counters.
module tb_halt_controller;

    localparam int INIT_CYC = 1;
    localparam longint MAX32 = 64'hFFFF_FFFF;
    localparam longint MAX4  = 15;

    typedef struct {
        logic       pc;
        logic       wr;
        logic       hl;
        logic [1:0] st;
        longint     cnt;
        longint     cnt4;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    halt_controller_if #(.OPCODE_W(6)) u_if ();

`ifdef HALT_CYCLE_COUNT_EN
    logic [31:0] cc;
    logic [3:0]  cc4;
    halt_controller_if #(.OPCODE_W(6)) u_if4 ();
    assign u_if4.opcode      = u_if.opcode;
    assign u_if4.instr_valid = u_if.instr_valid;
    assign u_if4.resume      = u_if.resume;

    halt_controller #(
        .INIT_CYCLES (INIT_CYC),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (u_if),
        .cycle_count (cc)
    );

    halt_controller #(
        .INIT_CYCLES (INIT_CYC),
        .CNT_W       (4)
    ) dut4 (
        .clk         (clk),
        .rst         (rst),
        .bus         (u_if4),
        .cycle_count (cc4)
    );
`else
    halt_controller #(
        .INIT_CYCLES (INIT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );
`endif

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Model: mode 0=INIT 1=RUN 2=HALTED, INIT cycles left, run counts.
    int     m_mode = 0;
    int     m_left = (INIT_CYC < 1) ? 1 : INIT_CYC;
    longint m_cnt  = 0;
    longint m_cnt4 = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit iv,
                        input logic [5:0] op, input bit res);
        exp_t e;
        bit   hit;
        @(posedge clk);
        #1;
        rst            = r;
        u_if.instr_valid = iv;
        u_if.opcode      = op;
        u_if.resume      = res;
        hit    = iv && (op == 6'h3F);
        e.pc   = 1'b0;
        e.wr   = 1'b0;
        e.hl   = 1'b0;
        e.st   = 2'd0;
        e.cnt  = m_cnt;
        e.cnt4 = m_cnt4;
        if (!r) begin
            if (m_mode == 1) begin
                e.pc = !hit;
                e.wr = !hit;
                e.st = 2'd1;
            end else if (m_mode == 2) begin
                e.pc = res;
                e.hl = 1'b1;
                e.st = 2'd2;
            end
        end
        q.push_back(e);
        if (r) begin
            m_mode = 0;
            m_left = (INIT_CYC < 1) ? 1 : INIT_CYC;
            m_cnt  = 0;
            m_cnt4 = 0;
        end else if (m_mode == 0) begin
            m_left--;
            if (m_left == 0) m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_cnt < MAX32) m_cnt++;
            if (m_cnt4 < MAX4) m_cnt4++;
            if (hit) m_mode = 2;
        end else if (res) begin
            m_mode = 1;
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_en", 64'(u_if.pc_en), 64'(e.pc));
            chk("wr_en_gate", 64'(u_if.wr_en_gate), 64'(e.wr));
            chk("halted", 64'(u_if.halted), 64'(e.hl));
            chk("state", 64'(u_if.state), 64'(e.st));
`ifdef HALT_CYCLE_COUNT_EN
            chk("cycle_count", 64'(cc), 64'(e.cnt));
            chk("cycle_count_w4", 64'(cc4), 64'(e.cnt4));
            chk("w4_state", 64'(u_if4.state), 64'(e.st));
`endif
        end
    end

    initial begin
        u_if.instr_valid = 1'b0;
        u_if.opcode      = 6'h00;
        u_if.resume      = 1'b0;
        // reset, INIT, then 5 RUN cycles, halt, 20 HALTED cycles
        step(1, 0, 6'h00, 0);
        step(1, 0, 6'h00, 0);
        step(0, 0, 6'h00, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 6'h01, 0);
        step(0, 1, 6'h3F, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 6'h3F, 0);
        // resume, then HALT opcode without instr_valid, resume in RUN
        step(0, 0, 6'h00, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 6'h3F, 0);
        step(0, 1, 6'h05, 1);
        step(0, 0, 6'h3F, 1);
        step(0, 1, 6'h3F, 0);
        step(0, 0, 6'h00, 0);
        // reset together with resume while HALTED
        step(1, 0, 6'h00, 1);
        step(0, 0, 6'h00, 0);
        // long RUN to saturate the 4-bit counter
        for (int i = 0; i < 22; i++) step(0, 1, 6'h2A, 0);
        step(0, 1, 6'h3F, 0);
        step(0, 0, 6'h00, 0);
        // reset from RUN mid-stream
        step(0, 0, 6'h00, 1);
        step(0, 1, 6'h10, 0);
        step(1, 1, 6'h10, 0);
        step(0, 1, 6'h10, 0);
        for (int i = 0; i < 3000; i++) begin
            bit         r;
            bit         iv;
            bit         res;
            logic [5:0] op;
            r   = ($urandom_range(0, 99) == 0);
            iv  = ($urandom_range(0, 1) == 1);
            op  = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom);
            res = ($urandom_range(0, 7) == 0);
            step(r, iv, op, res);
        end
        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/halt_controller.md
HALT_CONTROLLER -- requirements
Module: halt_controller

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 1: cycles held in INIT after rst deasserts, for instruction-memory initialisation.
REQ-002 SHALL have parameter OPCODE_W, default 6: width of the opcode input.
REQ-003 SHALL have parameter HALT_OPCODE, default 6'h3F: the opcode that means HALT.
REQ-004 SHALL have parameter CNT_W, default 32: width of cycle_count.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port opcode, input, OPCODE_W: opcode of the instruction at the current PC.
REQ-008 SHALL have port instr_valid, input, 1: opcode is meaningful this cycle.
REQ-009 SHALL have port resume, input, 1: single-cycle request to leave HALTED.
REQ-010 SHALL have port pc_en, output, 1: PC register may update this cycle.
REQ-011 SHALL have port wr_en_gate, output, 1: AND-mask for register-file and data-memory write enables.
REQ-012 SHALL have port halted, output, 1: processor is in HALTED.
REQ-013 SHALL have port state, output, 2: encoding INIT=0, RUN=1, HALTED=2; 3 is unused.
REQ-014 SHALL have port cycle_count, output, CNT_W: present only when the macro in REQ-030 is defined.

Function
REQ-015 SHALL implement a three-state FSM (INIT, RUN, HALTED) with a down-counter init_cnt of width $clog2(INIT_CYCLES+1), minimum 1.
REQ-016 INIT: SHALL hold pc_en=0, wr_en_gate=0, halted=0; decrement init_cnt each cycle; go to RUN on the cycle after init_cnt==0.
REQ-017 INIT_CYCLES=0: SHALL go from INIT to RUN on the first cycle after rst deasserts.
REQ-018 RUN with no halt hit: SHALL assert pc_en=1 and wr_en_gate=1.
REQ-019 Halt hit (RUN, instr_valid=1, opcode==HALT_OPCODE): SHALL drive pc_en=0 and wr_en_gate=0 combinationally in that same cycle, and move to HALTED next cycle.
REQ-020 Effect of REQ-019: the PC stays on the HALT instruction, and HALT commits no writes.
REQ-021 RUN with instr_valid=0: SHALL ignore opcode and never halt.
REQ-022 HALTED: SHALL hold pc_en=0, wr_en_gate=0, halted=1.
REQ-023 resume=1 in HALTED: SHALL assert pc_en=1 and wr_en_gate=0 in that cycle, so the PC steps past HALT, and move to RUN next cycle.
REQ-024 resume in INIT or RUN: SHALL be ignored.
REQ-025 All outputs SHALL be Moore decodes of the registered state, except the same-cycle gating in REQ-019 and REQ-023.
REQ-026 Unused state encoding 3: SHALL go to INIT on the next cycle, with outputs as INIT.

Reset
REQ-027 rst=1 at a clock edge: SHALL force state=INIT and init_cnt=INIT_CYCLES, and clear cycle_count, regardless of current state or of resume.
REQ-028 While rst=1: outputs SHALL read pc_en=0, wr_en_gate=0, halted=0, state=0.
REQ-029 Reset in mid-RUN or mid-HALTED: SHALL restart the full INIT sequence, and no write SHALL be enabled in the reset cycle.

Configuration
REQ-030 Macro HALT_CYCLE_COUNT_EN defined: SHALL provide the cycle_count port.
REQ-031 cycle_count SHALL increment once per RUN cycle, including the halt-hit cycle.
REQ-032 cycle_count SHALL hold its value in INIT and HALTED, and saturate at all-ones.
REQ-033 Macro not defined: the port, the counter and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-034 A shared package SHALL hold the state enum (INIT/RUN/HALTED), the 2-bit state width and the default HALT_OPCODE constant; the processor decoder SHALL import the same constant.
REQ-035 The block SHALL be a single module; the optional saturating counter MAY be a sub-module named sat_counter.

Verification
REQ-036 Bench SHALL cover: rst=1 for 2 cycles then 0, INIT_CYCLES=1 -> state 0,0,0 then RUN on the 2nd post-reset cycle; pc_en=1 from then on.
REQ-037 Bench SHALL cover: RUN, instr_valid=1, opcode=6'h3F -> pc_en=0 and wr_en_gate=0 in the same cycle; halted=1 and state=2 next cycle; pc_en stays 0 for 10 further cycles.
REQ-038 Bench SHALL cover: opcode=6'h3F with instr_valid=0 -> stays in RUN, pc_en=1.
REQ-039 Bench SHALL cover: HALTED, resume pulse -> pc_en=1 and wr_en_gate=0 that cycle; state=1 next cycle; resume pulsed in RUN -> no effect.
REQ-040 Bench SHALL cover: rst=1 together with resume=1 in HALTED -> state=0 next cycle, and cycle_count=0 when HALT_CYCLE_COUNT_EN is defined.
REQ-041 Bench SHALL cover (HALT_CYCLE_COUNT_EN defined): 5 RUN cycles then halt -> cycle_count=6, held at 6 for 20 HALTED cycles; CNT_W=4 with 20 RUN cycles -> cycle_count saturates at 15.
